// File: rtl/nids_pkg.sv
// Shared definitions for the NIDS packet injector: FSM encoding and frame geometry.
package nids_pkg;

    localparam int BYTES_PER_WORD      = 4;
    localparam int DEFAULT_FRAME_WORDS = 20;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WAIT_OK,
        SEND,
        WAIT_VERDICT,
        ACK
    } state_t;

endpackage

// File: rtl/frame_ram.sv
// Frame memory: DEPTH x 32 register file, one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module frame_ram
    import nids_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FRAME_WORDS
) (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pkt_injector.sv
// Streams a stored frame byte-by-byte to a NIDS and reports its verdict to the host.
// Optional wait-state timeout is enabled by defining PKT_INJECTOR_TIMEOUT_EN.
module pkt_injector
    import nids_pkg::*;
#(
    parameter int FRAME_WORDS    = DEFAULT_FRAME_WORDS,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        send,
    output logic        busy,
    output logic        nids_rx_init,
    output logic [7:0]  nids_data,
    input  logic        nids_rx_ok,
    input  logic        nids_tx_init,
    input  logic [2:0]  nids_tx_drop,
    output logic        nids_tx_ok,
    output logic        verdict_valid,
    output logic [2:0]  verdict_drop,
    output logic        timeout_err,
    output logic [4:0]  word_offset,
    output logic [1:0]  byte_offset
);

    state_t      state;
    state_t      next_state;
    logic        have_verdict;
    logic [2:0]  drop_q;
    logic [31:0] rd_word;
    logic [7:0]  byte_sel;
    logic        ram_we;
    logic        last_byte;

    assign busy          = (state != IDLE);
    assign nids_rx_init  = (state == INIT);
    assign nids_tx_ok    = (state == ACK);
    assign verdict_valid = (state == ACK);

    assign ram_we    = wr_en && !busy && ({27'd0, wr_addr} < 32'(FRAME_WORDS));
    assign last_byte = (word_offset == 5'(FRAME_WORDS - 1)) &&
                       (byte_offset == 2'(BYTES_PER_WORD - 1));

    frame_ram #(.DEPTH(FRAME_WORDS)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (word_offset),
        .rdata (rd_word)
    );

    // Most significant byte of each word goes out first.
    always_comb begin
        byte_sel = 8'h00;
        case (byte_offset)
            2'd0: byte_sel = rd_word[31:24];
            2'd1: byte_sel = rd_word[23:16];
            2'd2: byte_sel = rd_word[15:8];
            2'd3: byte_sel = rd_word[7:0];
            default: byte_sel = 8'h00;
        endcase
    end

    assign nids_data = (state == SEND) ? byte_sel : 8'h00;

`ifdef PKT_INJECTOR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;
    logic          timeout_q;

    assign timeout_hit = ((state == WAIT_OK) || (state == WAIT_VERDICT)) &&
                         (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_q;

    // The wait counter restarts on every state change, so each wait state gets a full budget.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state != next_state) begin
                wait_cnt <= '0;
            end else if ((state == WAIT_OK) || (state == WAIT_VERDICT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if ((state == IDLE) && send) begin
                timeout_q <= 1'b0;
            end else if (timeout_hit && (next_state == IDLE)) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (send) next_state = INIT;
            INIT:    next_state = WAIT_OK;
            WAIT_OK: begin
                if (nids_rx_ok) next_state = SEND;
`ifdef PKT_INJECTOR_TIMEOUT_EN
                else if (timeout_hit) next_state = IDLE;
`endif
            end
            SEND:    if (last_byte) next_state = WAIT_VERDICT;
            WAIT_VERDICT: begin
                if (have_verdict || nids_tx_init) next_state = ACK;
`ifdef PKT_INJECTOR_TIMEOUT_EN
                else if (timeout_hit) next_state = IDLE;
`endif
            end
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Only the first verdict strobe of a frame is kept; an early one just shortens WAIT_VERDICT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            word_offset  <= 5'd0;
            byte_offset  <= 2'd0;
            have_verdict <= 1'b0;
            drop_q       <= 3'd0;
            verdict_drop <= 3'd0;
        end else begin
            state <= next_state;
            if ((state == SEND) && !last_byte) begin
                if (byte_offset == 2'(BYTES_PER_WORD - 1)) begin
                    byte_offset <= 2'd0;
                    word_offset <= word_offset + 5'd1;
                end else begin
                    byte_offset <= byte_offset + 2'd1;
                end
            end else begin
                word_offset <= 5'd0;
                byte_offset <= 2'd0;
            end
            if ((state == IDLE) && send) begin
                have_verdict <= 1'b0;
            end else if (((state == SEND) || (state == WAIT_VERDICT)) &&
                         nids_tx_init && !have_verdict) begin
                have_verdict <= 1'b1;
                drop_q       <= nids_tx_drop;
            end
            if ((state == WAIT_VERDICT) && (next_state == ACK)) begin
                verdict_drop <= have_verdict ? drop_q : nids_tx_drop;
            end
        end
    end

endmodule

// File: tb/tb_pkt_injector.sv
// Self-checking bench for pkt_injector: randomized frames checked against a
// cycle-timeline model derived from the protocol rules (PKT_INJECTOR_TIMEOUT_EN aware).
module tb_pkt_injector;

    localparam int FW = 20;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        send;
    logic        busy;
    logic        nids_rx_init;
    logic [7:0]  nids_data;
    logic        nids_rx_ok;
    logic        nids_tx_init;
    logic [2:0]  nids_tx_drop;
    logic        nids_tx_ok;
    logic        verdict_valid;
    logic [2:0]  verdict_drop;
    logic        timeout_err;
    logic [4:0]  word_offset;
    logic [1:0]  byte_offset;

    int          compare_count  = 0;
    int          mismatch_count = 0;
    logic [31:0] mem_model [FW];
    logic [2:0]  last_drop;

    pkt_injector #(.FRAME_WORDS(FW), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .send          (send),
        .busy          (busy),
        .nids_rx_init  (nids_rx_init),
        .nids_data     (nids_data),
        .nids_rx_ok    (nids_rx_ok),
        .nids_tx_init  (nids_tx_init),
        .nids_tx_drop  (nids_tx_drop),
        .nids_tx_ok    (nids_tx_ok),
        .verdict_valid (verdict_valid),
        .verdict_drop  (verdict_drop),
        .timeout_err   (timeout_err),
        .word_offset   (word_offset),
        .byte_offset   (byte_offset)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s at %0t: observed 0x%0h, expected 0x%0h", tag, $time, observed, expected);
        end
    endtask

    function automatic logic [7:0] frame_byte(input int idx);
        logic [31:0] w;
        w = mem_model[idx / 4];
        return 8'(w >> (8 * (3 - (idx % 4))));
    endfunction

    task automatic check_reset_outputs(input string tag);
        checkOutput(tag, {9'd0, busy, nids_rx_init, nids_data, nids_tx_ok, verdict_valid,
                          verdict_drop, timeout_err, word_offset, byte_offset}, 32'd0);
    endtask

    task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        if (int'(addr) < FW) mem_model[addr] = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // d: extra WAIT_OK cycles before rx_ok; early: verdict strobe at SEND byte strobe_off,
    // otherwise strobe_off cycles into WAIT_VERDICT; abort_at: byte index to reset at (-1 none).
    task automatic run_frame(input int d, input bit early, input int strobe_off, input logic [2:0] drop,
                             input bit guard, input bit co_write, input int abort_at);
        int          send_start, wv, strobe_cycle, ack, idx;
        bit          in_send;
        logic [4:0]  ca;
        logic [31:0] cd;
        send_start   = 3 + d;
        wv           = send_start + FW * 4;
        strobe_cycle = early ? send_start + strobe_off : wv + strobe_off;
        ack          = early ? wv + 1 : strobe_cycle + 1;
        @(negedge clk);
        send = 1'b1;
        if (co_write) begin
            ca      = 5'($urandom_range(0, FW + 3));
            cd      = $urandom;
            wr_en   = 1'b1;
            wr_addr = ca;
            wr_data = cd;
            if (int'(ca) < FW) mem_model[ca] = cd;
        end
        for (int c = 1; c <= ack + 2; c++) begin
            @(negedge clk);
            in_send = (c >= send_start) && (c < wv);
            idx     = c - send_start;
            checkOutput("busy", 32'(busy), 32'(c <= ack));
            checkOutput("rx_init", 32'(nids_rx_init), 32'(c == 1));
            checkOutput("nids_data", 32'(nids_data), 32'(in_send ? frame_byte(idx) : 8'h00));
            if (in_send) begin
                checkOutput("word_offset", 32'(word_offset), 32'(idx / 4));
                checkOutput("byte_offset", 32'(byte_offset), 32'(idx % 4));
            end
            checkOutput("tx_ok", 32'(nids_tx_ok), 32'(c == ack));
            checkOutput("verdict_valid", 32'(verdict_valid), 32'(c == ack));
            checkOutput("verdict_drop", 32'(verdict_drop), 32'((c >= ack) ? drop : last_drop));
            checkOutput("timeout_err", 32'(timeout_err), 32'd0);
            if (abort_at >= 0 && c == send_start + abort_at) begin
                rst = 1'b0;
                #1 check_reset_outputs("abort_async");
                send = 1'b0; wr_en = 1'b0; nids_rx_ok = 1'b0; nids_tx_init = 1'b0;
                @(negedge clk) check_reset_outputs("abort_next");
                rst       = 1'b1;
                last_drop = 3'd0;
                return;
            end
            send         = guard && (c == send_start + 5);
            wr_en        = guard && (c == send_start + 5);
            wr_addr      = 5'd0;
            wr_data      = 32'hFFFF_FFFF;
            nids_rx_ok   = (c >= 2 + d);
            nids_tx_init = (c == strobe_cycle) || ((c == strobe_cycle + 1) && (c < ack));
            nids_tx_drop = (c == strobe_cycle) ? drop : ((c == strobe_cycle + 1) ? ~drop : 3'($urandom));
        end
        nids_rx_ok   = 1'b0;
        nids_tx_init = 1'b0;
        last_drop    = drop;
    endtask

`ifdef PKT_INJECTOR_TIMEOUT_EN
    task automatic run_timeout();
        @(negedge clk);
        send       = 1'b1;
        nids_rx_ok = 1'b0;
        for (int c = 1; c <= TO + 4; c++) begin
            @(negedge clk);
            send = 1'b0;
            checkOutput("to_busy", 32'(busy), 32'(c <= TO + 1));
            checkOutput("to_err", 32'(timeout_err), 32'(c >= TO + 2));
            checkOutput("to_data", 32'(nids_data), 32'd0);
            checkOutput("to_tx_ok", 32'({nids_tx_ok, verdict_valid}), 32'd0);
        end
    endtask
`endif

    initial begin
        bit e;
        rst = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0; send = 1'b0;
        nids_rx_ok = 1'b0; nids_tx_init = 1'b0; nids_tx_drop = 3'd0;
        last_drop = 3'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        applyStimulus(5'd0, 32'h4500_0028);
        applyStimulus(5'd1, 32'h0001_0000);
        for (int i = 2; i < FW; i++) applyStimulus(5'(i), $urandom);
        applyStimulus(5'd20, 32'hDEAD_BEEF);
        applyStimulus(5'd31, 32'hCAFE_F00D);

        $display("[TB] nominal frame");
        run_frame(1, 1'b0, 3, 3'b111, 1'b0, 1'b0, -1);
        $display("[TB] early verdict");
        run_frame(0, 1'b1, 40, 3'b000, 1'b0, 1'b0, -1);
        $display("[TB] busy guard");
        run_frame(2, 1'b0, 1, 3'b101, 1'b1, 1'b0, -1);
        run_frame(0, 1'b0, 0, 3'b010, 1'b0, 1'b0, -1);

`ifdef PKT_INJECTOR_TIMEOUT_EN
        $display("[TB] wait timeout");
        run_timeout();
`else
        $display("[TB] long wait without timeout");
        run_frame(40, 1'b0, 30, 3'b011, 1'b0, 1'b0, -1);
`endif

        $display("[TB] reset mid-frame");
        run_frame(1, 1'b0, 2, 3'b110, 1'b0, 1'b0, 37);
        run_frame(0, 1'b0, 2, 3'b100, 1'b0, 1'b0, -1);

        $display("[TB] randomized frames");
        for (int n = 0; n < 6; n++) begin
            applyStimulus(5'($urandom_range(0, 31)), $urandom);
            applyStimulus(5'($urandom_range(0, FW - 1)), $urandom);
            e = 1'($urandom_range(0, 1));
            run_frame(int'($urandom_range(0, 5)), e,
                      e ? int'($urandom_range(0, FW * 4 - 1)) : int'($urandom_range(0, 5)),
                      3'($urandom), 1'b0, 1'b1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
